edp_mds_seq: RTL and testbench

Multiply/divide step sequencer for the EBOX data path. On a start request it drives the EDP mux-select and load-enable controls cycle by cycle. Multiply runs radix-4 Booth steps: 2 bits per step, AR/ARX/MQ shifted right 2. Divide runs non-restoring steps: 1 bit per step, AR/ARX/MQ shifted left 1, with an optional final remainder-correction cycle. It sits between microcode dispatch (CTL) and the EDP control inputs, and owns those inputs only while busy.

---
 rtl/edp_mds_seq_if.sv | 45 ++++
 rtl/edp_mds_seq.sv | 197 +++++++++++++++++++
 tb/tb_edp_mds_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edp_mds_seq_if.sv
// edp_mds_seq_if: bundle between the dispatcher/data path and the multiply/divide
// step sequencer.
//
// Handshake: start is sampled only while busy=0. The cycle after an accepted start,
// busy rises and stays high through the DONE cycle. done pulses for exactly that
// last cycle. abort (or reset) drops busy on the next edge without a done pulse.
// While busy=0 every ctl* output holds the idle vector (all zeros).
interface edp_mds_seq_if;
    // requests and data-path status into the sequencer
    logic       start;
    logic       isDiv;
    logic [5:0] nSteps;
    logic       abort;
    logic       mq34;
    logic       mq35;
    logic       adSign;
    // status and EDP controls out of the sequencer
    logic       busy;
    logic       done;
    logic [5:0] stepCnt;
    logic [2:0] ctlArlSel;
    logic [2:0] ctlArxlSel;
    logic [2:0] ctlArxrSel;
    logic       ctlArLoad;
    logic       ctlArxLoad;
    logic       ctlMqmEn;
    logic [1:0] ctlMqmSel;
    logic [1:0] ctlMqSel;
    logic [1:0] ctlAdb;
    logic [1:0] ctlAdFunc;

    // dispatcher / data-path side
    modport master (
        output start, isDiv, nSteps, abort, mq34, mq35, adSign,
        input  busy, done, stepCnt, ctlArlSel, ctlArxlSel, ctlArxrSel,
               ctlArLoad, ctlArxLoad, ctlMqmEn, ctlMqmSel, ctlMqSel, ctlAdb, ctlAdFunc
    );

    // sequencer side
    modport slave (
        input  start, isDiv, nSteps, abort, mq34, mq35, adSign,
        output busy, done, stepCnt, ctlArlSel, ctlArxlSel, ctlArxrSel,
               ctlArLoad, ctlArxLoad, ctlMqmEn, ctlMqmSel, ctlMqSel, ctlAdb, ctlAdFunc
    );
endinterface

// File: rtl/edp_mds_seq.sv
// edp_mds_seq: multiply/divide step sequencer for the EBOX data path.
// Multiply: radix-4 Booth steps (AR/ARX/MQ shift right 2 per step).
// Divide: non-restoring steps (AR/ARX/MQ shift left 1 per step).
// Optional macro MDSEQ_REM_FIX_EN adds a final remainder-correction (FIX) cycle
// after the last divide step; without it the remainder is left for microcode.
// The FSM state is exported on dbg_state_o.
module edp_mds_seq (
    input  logic              clk,
    input  logic              reset,
    edp_mds_seq_if.slave      bus,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [1:0] FN_PASS  = 2'b00;
    localparam logic [1:0] FN_ADD   = 2'b01;
    localparam logic [1:0] FN_SUB   = 2'b10;
    localparam logic [1:0] ADB_NONE = 2'b00;
    localparam logic [1:0] ADB_2B   = 2'b01;
    localparam logic [1:0] ADB_B    = 2'b10;

    state_e     state_q;
    logic [5:0] step_cnt_q;
    logic [5:0] step_cnt_d;
    logic       prev_q;
    logic       last_neg_q;
    logic       busy_q;
    logic       done_q;
    logic       last_step;

    logic [2:0] arl_sel;
    logic [2:0] arxl_sel;
    logic [2:0] arxr_sel;
    logic       ar_load;
    logic       arx_load;
    logic       mqm_en;
    logic [1:0] mqm_sel;
    logic [1:0] mq_sel;
    logic [1:0] adb;
    logic [1:0] ad_func;

    // Remaining-step count after this step; saturates so it can never wrap below 0.
    assign step_cnt_d = (step_cnt_q == 6'd0) ? 6'd0 : step_cnt_q - 6'd1;
    // The step taken with one step remaining is the last one.
    assign last_step  = (step_cnt_q <= 6'd1);

    // Sequencer FSM: state, step counter, Booth history, divide sign and registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            step_cnt_q <= 6'd0;
            prev_q     <= 1'b0;
            last_neg_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (bus.abort) begin
            // abort beats everything, including a simultaneous start; the count is kept
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        step_cnt_q <= bus.nSteps;
                        prev_q     <= 1'b0;
                        last_neg_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if (bus.nSteps == 6'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= bus.isDiv ? ST_DIV : ST_MUL;
                            done_q  <= 1'b0;
                        end
                    end
                end
                ST_MUL: begin
                    prev_q     <= bus.mq34;
                    step_cnt_q <= step_cnt_d;
                    if (last_step) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DIV: begin
                    last_neg_q <= bus.adSign;
                    step_cnt_q <= step_cnt_d;
                    if (last_step) begin
`ifdef MDSEQ_REM_FIX_EN
                        state_q <= ST_FIX;
`else
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
`endif
                    end
                end
                ST_FIX: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // EDP control decode; the idle vector wins whenever abort or reset is present,
    // so nothing is loaded in the cycle the operation is cancelled.
    always_comb begin
        arl_sel  = 3'b000;
        arxl_sel = 3'b000;
        arxr_sel = 3'b000;
        ar_load  = 1'b0;
        arx_load = 1'b0;
        mqm_en   = 1'b0;
        mqm_sel  = 2'b00;
        mq_sel   = 2'b00;
        adb      = ADB_NONE;
        ad_func  = FN_PASS;
        if (!reset && !bus.abort) begin
            case (state_q)
                ST_MUL: begin
                    arl_sel  = 3'b111;
                    arxl_sel = 3'b111;
                    arxr_sel = 3'b111;
                    ar_load  = 1'b1;
                    arx_load = 1'b1;
                    mqm_en   = 1'b1;
                    mqm_sel  = 2'b00;
                    mq_sel   = 2'b11;
                    // radix-4 Booth recode of {MQ34, MQ35, previous MQ34}
                    case ({bus.mq34, bus.mq35, prev_q})
                        3'b001, 3'b010: begin ad_func = FN_ADD;  adb = ADB_B;    end
                        3'b011:         begin ad_func = FN_ADD;  adb = ADB_2B;   end
                        3'b100:         begin ad_func = FN_SUB;  adb = ADB_2B;   end
                        3'b101, 3'b110: begin ad_func = FN_SUB;  adb = ADB_B;    end
                        default:        begin ad_func = FN_PASS; adb = ADB_NONE; end
                    endcase
                end
                ST_DIV: begin
                    arl_sel  = 3'b101;
                    arxl_sel = 3'b101;
                    arxr_sel = 3'b101;
                    ar_load  = 1'b1;
                    arx_load = 1'b1;
                    mq_sel   = 2'b01;
                    adb      = ADB_B;
                    // last_neg_q is cleared at start, so the first step subtracts
                    ad_func  = last_neg_q ? FN_ADD : FN_SUB;
                end
                ST_FIX: begin
                    // restore a negative remainder by adding the divisor back into AR
                    if (last_neg_q) begin
                        arl_sel = 3'b010;
                        ar_load = 1'b1;
                        adb     = ADB_B;
                        ad_func = FN_ADD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.stepCnt    = step_cnt_q;
    assign bus.ctlArlSel  = arl_sel;
    assign bus.ctlArxlSel = arxl_sel;
    assign bus.ctlArxrSel = arxr_sel;
    assign bus.ctlArLoad  = ar_load;
    assign bus.ctlArxLoad = arx_load;
    assign bus.ctlMqmEn   = mqm_en;
    assign bus.ctlMqmSel  = mqm_sel;
    assign bus.ctlMqSel   = mq_sel;
    assign bus.ctlAdb     = adb;
    assign bus.ctlAdFunc  = ad_func;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_edp_mds_seq.sv
// tb_edp_mds_seq: bench for edp_mds_seq with an operation-level reference model.
// Build with or without MDSEQ_REM_FIX_EN; the model follows the same macro.
module tb_edp_mds_seq;

`ifdef MDSEQ_REM_FIX_EN
    localparam int FIX_EN = 1;
`else
    localparam int FIX_EN = 0;
`endif

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    edp_mds_seq_if bus();

    edp_mds_seq u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         errors = 0;
    int         checks = 0;
    bit         chk_en = 1'b0;
    logic [7:0] exp_q[$];   // expected start-to-done latencies

    logic [19:0] act_ctl;
    assign act_ctl = {bus.ctlArlSel, bus.ctlArxlSel, bus.ctlArxrSel, bus.ctlArLoad,
                      bus.ctlArxLoad, bus.ctlMqmEn, bus.ctlMqmSel, bus.ctlMqSel,
                      bus.ctlAdb, bus.ctlAdFunc};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // An operation is described by its kind, step count n and the cycle index k
    // since acceptance (k=1 is the first step). Steps occupy k=1..n, an optional
    // fix cycle follows for divide, and the done cycle comes last.
    bit m_active  = 1'b0;
    bit m_div     = 1'b0;
    int m_n       = 0;
    int m_k       = 0;
    bit m_prev    = 1'b0;
    bit m_lastneg = 1'b0;
    int m_cnt     = 0;

    function automatic int done_k();
        if (m_n == 0) return 1;
        return m_n + 1 + ((m_div && FIX_EN != 0) ? 1 : 0);
    endfunction

    function automatic int cur_cnt();
        if (!m_active)  return m_cnt;
        if (m_k <= m_n) return m_n - m_k + 1;
        return 0;
    endfunction

    function automatic logic [19:0] exp_ctl(input logic rst, input logic ab,
                                            input logic q34, input logic q35);
        int         d;
        logic [1:0] fn;
        logic [1:0] ab_sel;
        if (rst || ab || !m_active) return 20'd0;
        if (m_k <= m_n) begin
            if (!m_div) begin
                // Booth digit in -2..+2
                d = int'(q35) + int'(m_prev) - 2 * int'(q34);
                fn     = (d == 0) ? 2'b00 : ((d > 0) ? 2'b01 : 2'b10);
                ab_sel = (d == 0) ? 2'b00 : ((d == 2 || d == -2) ? 2'b01 : 2'b10);
                return {3'b111, 3'b111, 3'b111, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11, ab_sel, fn};
            end
            fn = (m_k == 1) ? 2'b10 : (m_lastneg ? 2'b01 : 2'b10);
            return {3'b101, 3'b101, 3'b101, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'b10, fn};
        end
        if (m_div && FIX_EN != 0 && m_n > 0 && m_k == m_n + 1 && m_lastneg)
            return {3'b010, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b10, 2'b01};
        return 20'd0;
    endfunction

    // model advance on each clock edge
    always @(posedge clk) begin
        if (reset) begin
            m_active  <= 1'b0;
            m_cnt     <= 0;
            m_prev    <= 1'b0;
            m_lastneg <= 1'b0;
        end else if (bus.abort) begin
            m_cnt    <= cur_cnt();
            m_active <= 1'b0;
        end else if (!m_active) begin
            if (bus.start) begin
                m_active  <= 1'b1;
                m_div     <= bus.isDiv;
                m_n       <= int'(bus.nSteps);
                m_k       <= 1;
                m_prev    <= 1'b0;
                m_lastneg <= 1'b0;
            end
        end else if (m_k <= m_n) begin
            if (m_div) m_lastneg <= bus.adSign;
            else       m_prev    <= bus.mq34;
            m_k <= m_k + 1;
        end else if (m_k == done_k()) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
        end else begin
            m_k <= m_k + 1;
        end
    end

    // cycle-by-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",    32'(bus.busy),    32'(m_active));
            chk("done",    32'(bus.done),    32'(m_active && m_k == done_k()));
            chk("stepCnt", 32'(bus.stepCnt), 32'(cur_cnt()));
            chk("ctl",     32'(act_ctl),     32'(exp_ctl(reset, bus.abort, bus.mq34, bus.mq35)));
        end
    end

    // ---------------- driver ----------------
    logic [1:0] pat [0:8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b01};
    bit         use_pat = 1'b0;
    logic       ads [0:7];
    int         n_ads = 0;
    int         fix_exp = -1;
    logic [1:0] func_lit[$];
    logic [1:0] adb_lit[$];

    task automatic tick();
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.isDiv  = 1'($urandom_range(0, 1));
        bus.nSteps = 6'($urandom_range(0, 63));
        bus.mq34   = 1'($urandom_range(0, 1));
        bus.mq35   = 1'($urandom_range(0, 1));
        bus.adSign = 1'($urandom_range(0, 1));
    endtask

    task automatic run_op(input bit div, input int n, input int abort_at,
                          input int busy_start_at, input int reset_at, input int exp_lat);
        int c;
        bit fin;
        tick();
        bus.start  = 1'b1;
        bus.isDiv  = div;
        bus.nSteps = 6'(n);
        if (exp_lat > 0) exp_q.push_back(8'(exp_lat));
        c   = 0;
        fin = 1'b0;
        while (!fin && c < 200) begin
            tick();
            c++;
            if (use_pat && c <= n) {bus.mq34, bus.mq35} = pat[(c - 1) % 9];
            if (c <= n_ads) bus.adSign = ads[c - 1];
            if (c == abort_at) bus.abort = 1'b1;
            if (c == busy_start_at) bus.start = 1'b1;
            if (c == reset_at) reset = 1'b1;
            @(negedge clk);
            if (c <= func_lit.size()) chk("lit_func", 32'(bus.ctlAdFunc), 32'(func_lit[c - 1]));
            if (c <= adb_lit.size())  chk("lit_adb",  32'(bus.ctlAdb),    32'(adb_lit[c - 1]));
            if (div && fix_exp >= 0 && c == n + 1) begin
                chk("fix_arload",  32'(bus.ctlArLoad),  32'((FIX_EN != 0) ? fix_exp : 0));
                chk("fix_arxload", 32'(bus.ctlArxLoad), 32'd0);
                chk("fix_func",    32'(bus.ctlAdFunc),
                    32'((FIX_EN != 0 && fix_exp == 1) ? 2'b01 : 2'b00));
            end
            if (n == 0) chk("n0_ctl", 32'(act_ctl), 32'd0);
            if (c == busy_start_at) chk("busy_start_cnt", 32'(bus.stepCnt), 32'(n - c + 1));
            if (bus.done) begin
                fin = 1'b1;
                if (exp_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else                   chk("latency", 32'(c), 32'(exp_q.pop_front()));
            end else if (c == abort_at || c == reset_at) begin
                fin = 1'b1;
                chk("cancel_ctl", 32'(act_ctl), 32'd0);
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done after %0d cycles, required done within %0d", c, 200);
        end
        if (c == abort_at || c == reset_at) begin
            tick();
            reset = 1'b0;
            @(negedge clk);
            chk("post_cancel_busy", 32'(bus.busy), 32'd0);
            chk("post_cancel_done", 32'(bus.done), 32'd0);
            if (c == reset_at) begin
                chk("post_reset_cnt", 32'(bus.stepCnt), 32'd0);
                chk("post_reset_ctl", 32'(act_ctl),     32'd0);
            end
        end
        use_pat = 1'b0;
        n_ads   = 0;
        fix_exp = -1;
        func_lit.delete();
        adb_lit.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        bit dv;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.isDiv  = 1'b0;
        bus.nSteps = 6'd0;
        bus.mq34   = 1'b0;
        bus.mq35   = 1'b0;
        bus.adSign = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(bus.busy),    32'd0);
        chk("reset_done", 32'(bus.done),    32'd0);
        chk("reset_cnt",  32'(bus.stepCnt), 32'd0);
        chk("reset_ctl",  32'(act_ctl),     32'd0);

        // start together with abort in IDLE: abort wins
        tick();
        bus.start  = 1'b1;
        bus.abort  = 1'b1;
        bus.nSteps = 6'd5;
        tick();
        @(negedge clk);
        chk("start_abort_busy", 32'(bus.busy), 32'd0);

        // multiply, 18 steps, all eight recode patterns
        use_pat = 1'b1;
        func_lit = '{2'b00, 2'b01, 2'b10};
        adb_lit  = '{2'b00, 2'b10, 2'b01};
        run_op(1'b0, 18, 0, 0, 0, 19);
        chk("mul_end_cnt", 32'(bus.stepCnt), 32'd0);

        // divide, 3 steps, adSign 1,0,1: SUB, ADD, SUB then fix ADD
        ads[0] = 1'b1; ads[1] = 1'b0; ads[2] = 1'b1; n_ads = 3;
        fix_exp  = 1;
        func_lit = '{2'b10, 2'b01, 2'b10};
        run_op(1'b1, 3, 0, 0, 0, 4 + FIX_EN);

        // divide ending positive: fix cycle loads nothing
        ads[0] = 1'b1; ads[1] = 1'b0; n_ads = 2;
        fix_exp = 0;
        run_op(1'b1, 2, 0, 0, 0, 3 + FIX_EN);

        // zero-step operations
        run_op(1'b0, 0, 0, 0, 0, 1);
        run_op(1'b1, 0, 0, 0, 0, 1);

        // abort at step 5 of an 18-step multiply
        run_op(1'b0, 18, 5, 0, 0, 0);

        // start while busy is ignored, then reset mid-divide
        run_op(1'b1, 20, 0, 3, 8, 0);

        // randomized operations
        for (int i = 0; i < 30; i++) begin
            dv = 1'($urandom_range(0, 1));
            n  = $urandom_range(0, 12);
            if (n > 0 && $urandom_range(0, 4) == 0)
                run_op(dv, n, $urandom_range(1, n), 0, 0, 0);
            else if (n > 2 && $urandom_range(0, 3) == 0)
                run_op(dv, n, 0, $urandom_range(1, n), 0,
                       n + 1 + (dv ? FIX_EN : 0));
            else
                run_op(dv, n, 0, 0, 0, (n == 0) ? 1 : n + 1 + (dv ? FIX_EN : 0));
            repeat ($urandom_range(0, 2)) tick();
        end

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
